bip_datapath: RTL and testbench

//  Execution datapath of the BIP accumulator CPU, directly downstream of the control unit.

---
 rtl/bip_pkg.sv | 22 ++
 rtl/bip_alu.sv | 22 ++
 rtl/bip_datapath.sv | 128 ++++++++++++
 tb/tb_bip_datapath.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bip_pkg.sv
// BIP datapath shared definitions.
// Accumulator source selects, ALU opcodes and the control strobe bundle.
package bip_pkg;

  localparam logic [1:0] SELA_RAM  = 2'b00;
  localparam logic [1:0] SELA_IMM  = 2'b01;
  localparam logic [1:0] SELA_ALU  = 2'b10;
  localparam logic [1:0] SELA_HOLD = 2'b11;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic [1:0] sel_a;
    logic       sel_b;
    logic       wr_acc;
    logic       op;
    logic       wr_ram;
    logic       rd_ram;
  } ctrl_t;

endpackage

// File: rtl/bip_alu.sv
// BIP add/sub ALU.
// Pure combinational; results wrap modulo 2**NBITS.
module bip_alu
  import bip_pkg::*;
#(
  parameter int NBITS = 16
) (
  input  logic [NBITS-1:0] a,
  input  logic [NBITS-1:0] b,
  input  logic             op,
  output logic [NBITS-1:0] result
);

  always_comb begin
    result = a + b;
    unique case (op)
      OP_ADD: result = a + b;
      OP_SUB: result = a - b;
    endcase
  end

endmodule

// File: rtl/bip_datapath.sv
// BIP execution datapath: accumulator, sign extender, ALU, data RAM,
// sticky halt, cycle counter and a debug RAM read port.
module bip_datapath
  import bip_pkg::*;
#(
  parameter int NBITS_O = 11,
  parameter int NBITS_D = 16,
  parameter int NBITS_C = 32
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [1:0]         i_SelA,
  input  logic               i_SelB,
  input  logic               i_WrAcc,
  input  logic               i_Op,
  input  logic               i_WrRam,
  input  logic               i_RdRam,
  input  logic [NBITS_O-1:0] i_Operand,
  input  logic               i_Halt,
  input  logic [NBITS_O-1:0] i_DbgAddr,
  output logic [NBITS_D-1:0] o_Acc,
  output logic [NBITS_D-1:0] o_DbgData,
  output logic               o_Halted,
  output logic [NBITS_C-1:0] o_CycleCount
);

  localparam int DEPTH = 2 ** NBITS_O;

  logic [NBITS_D-1:0] mem [DEPTH];

  ctrl_t              ctrl;
  logic [NBITS_D-1:0] ext;
  logic [NBITS_D-1:0] rd_data;
  logic [NBITS_D-1:0] op_b;
  logic [NBITS_D-1:0] alu_res;
  logic [NBITS_D-1:0] acc_nxt;
  logic               acc_we;
  logic               halt_eff;
  logic               ram_we;

  assign ctrl = '{
    sel_a:  i_SelA,
    sel_b:  i_SelB,
    wr_acc: i_WrAcc,
    op:     i_Op,
    wr_ram: i_WrRam,
    rd_ram: i_RdRam
  };

  assign ext = {
    {(NBITS_D-NBITS_O){i_Operand[NBITS_O-1]}},
    i_Operand
  };

  assign rd_data = ctrl.rd_ram ? mem[i_Operand] : '0;
  assign op_b    = ctrl.sel_b ? ext : rd_data;

  bip_alu #(
    .NBITS (NBITS_D)
  ) u_alu (
    .a      (o_Acc),
    .b      (op_b),
    .op     (ctrl.op),
    .result (alu_res)
  );

  // The HLT cycle itself is already frozen.
  assign halt_eff = o_Halted | i_Halt;

  always_comb begin
    acc_nxt = o_Acc;
    acc_we  = 1'b0;
    unique case (ctrl.sel_a)
      SELA_RAM: begin
        acc_nxt = rd_data;
        acc_we  = ctrl.wr_acc;
      end
      SELA_IMM: begin
        acc_nxt = ext;
        acc_we  = ctrl.wr_acc;
      end
      SELA_ALU: begin
        acc_nxt = alu_res;
        acc_we  = ctrl.wr_acc;
      end
      SELA_HOLD: begin
        acc_nxt = o_Acc;
        acc_we  = 1'b0;
      end
    endcase
  end

  assign ram_we = !i_reset && !halt_eff && ctrl.wr_ram;

  // No reset: contents survive reset; old word is read this cycle.
  always_ff @(posedge i_clk) begin
    if (ram_we) begin
      mem[i_Operand] <= o_Acc;
    end
  end

  assign o_DbgData = mem[i_DbgAddr];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_Acc <= '0;
    end else if (!halt_eff && acc_we) begin
      o_Acc <= acc_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_Halted <= 1'b0;
    end else if (i_Halt) begin
      o_Halted <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_CycleCount <= '0;
    end else if (!halt_eff && (o_CycleCount != '1)) begin
      o_CycleCount <= o_CycleCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_bip_datapath.sv
// Directed and random checks of bip_datapath against a
// behavioural model of the accumulator machine.
module tb_bip_datapath;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [1:0]  i_SelA;
  logic        i_SelB;
  logic        i_WrAcc;
  logic        i_Op;
  logic        i_WrRam;
  logic        i_RdRam;
  logic [10:0] i_Operand;
  logic        i_Halt;
  logic [10:0] i_DbgAddr;
  logic [15:0] o_Acc;
  logic [15:0] o_DbgData;
  logic        o_Halted;
  logic [31:0] o_CycleCount;

  bip_datapath dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_SelA       (i_SelA),
    .i_SelB       (i_SelB),
    .i_WrAcc      (i_WrAcc),
    .i_Op         (i_Op),
    .i_WrRam      (i_WrRam),
    .i_RdRam      (i_RdRam),
    .i_Operand    (i_Operand),
    .i_Halt       (i_Halt),
    .i_DbgAddr    (i_DbgAddr),
    .o_Acc        (o_Acc),
    .o_DbgData    (o_DbgData),
    .o_Halted     (o_Halted),
    .o_CycleCount (o_CycleCount)
  );

  always #5 i_clk = ~i_clk;

  int errors = 0;
  int checks = 0;

  logic [15:0] ram_m [2048];
  logic [15:0] acc_m;
  logic        halted_m;
  logic [31:0] cyc_m;
  logic [10:0] dbg_addr;
  logic        init_phase;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_acc"}, 32'(o_Acc), 32'(acc_m));
    chk({tag, "_halted"}, 32'(o_Halted), 32'(halted_m));
    chk({tag, "_cycles"}, o_CycleCount, cyc_m);
    chk({tag, "_dbg"}, 32'(o_DbgData), 32'(ram_m[dbg_addr]));
  endtask

  // One instruction cycle; model is the machine's architectural rules.
  task automatic apply(input logic [1:0]  sela,
                       input logic        selb,
                       input logic        wracc,
                       input logic        op,
                       input logic        wrram,
                       input logic        rdram,
                       input logic [10:0] opnd,
                       input logic        halt,
                       input string       tag);
    logic [15:0] ext, rd, b, res;
    @(negedge i_clk);
    i_reset   = 1'b0;
    i_SelA    = sela;
    i_SelB    = selb;
    i_WrAcc   = wracc;
    i_Op      = op;
    i_WrRam   = wrram;
    i_RdRam   = rdram;
    i_Operand = opnd;
    i_Halt    = halt;
    i_DbgAddr = dbg_addr;
    #1;
    if (!init_phase) begin
      chk({tag, "_dbg_pre"}, 32'(o_DbgData), 32'(ram_m[dbg_addr]));
    end
    ext = 16'(signed'(opnd));
    rd  = rdram ? ram_m[opnd] : 16'h0;
    b   = selb ? ext : rd;
    res = op ? acc_m - b : acc_m + b;
    if (!(halted_m || halt)) begin
      if (wrram) ram_m[opnd] = acc_m;
      if (wracc) begin
        case (sela)
          2'd0:    acc_m = rd;
          2'd1:    acc_m = ext;
          2'd2:    acc_m = res;
          default: acc_m = acc_m;
        endcase
      end
      if (cyc_m != 32'hFFFF_FFFF) cyc_m = cyc_m + 1;
    end
    if (halt) halted_m = 1'b1;
    @(posedge i_clk);
    #1;
    if (!init_phase) chk_state(tag);
  endtask

  task automatic do_reset(input logic wr,
                          input logic [10:0] opnd,
                          input string tag);
    @(negedge i_clk);
    i_reset   = 1'b1;
    i_SelA    = 2'b01;
    i_SelB    = 1'b0;
    i_WrAcc   = 1'b1;
    i_Op      = 1'b0;
    i_WrRam   = wr;
    i_RdRam   = 1'b0;
    i_Operand = opnd;
    i_Halt    = 1'b0;
    i_DbgAddr = dbg_addr;
    @(posedge i_clk);
    #1;
    acc_m    = '0;
    halted_m = 1'b0;
    cyc_m    = '0;
    chk_state(tag);
  endtask

  task automatic ldi(input logic [10:0] v, input string tag);
    apply(2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, v, 1'b0, tag);
  endtask

  task automatic addi(input logic [10:0] v, input logic op,
                      input string tag);
    apply(2'b10, 1'b1, 1'b1, op, 1'b0, 1'b0, v, 1'b0, tag);
  endtask

  task automatic sto(input logic [10:0] a, input string tag);
    apply(2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, a, 1'b0, tag);
  endtask

  task automatic nop(input string tag);
    apply(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h0, 1'b0, tag);
  endtask

  initial begin
    i_reset   = 1'b1;
    i_SelA    = 2'b11;
    i_SelB    = 1'b0;
    i_WrAcc   = 1'b0;
    i_Op      = 1'b0;
    i_WrRam   = 1'b0;
    i_RdRam   = 1'b0;
    i_Operand = '0;
    i_Halt    = 1'b0;
    i_DbgAddr = '0;
    dbg_addr  = '0;
    acc_m     = '0;
    halted_m  = 1'b0;
    cyc_m     = '0;
    for (int a = 0; a < 2048; a++) ram_m[a] = 16'h0;

    do_reset(1'b0, 11'h0, "reset");

    // Zero every word so the model and RAM agree on all addresses.
    init_phase = 1'b1;
    for (int a = 0; a < 2048; a++) sto(11'(a), "init");
    init_phase = 1'b0;

    // LDI and sign extension
    ldi(11'h005, "ldi_pos");
    chk("ldi_pos_const", 32'(o_Acc), 32'h0005);
    ldi(11'h7FF, "ldi_neg");
    chk("ldi_neg_const", 32'(o_Acc), 32'hFFFF);

    // Build 0x1234, store at 3, reload
    ldi(11'h3FF, "build0");
    for (int i = 0; i < 3; i++) addi(11'h3FF, 1'b0, "build");
    addi(11'h238, 1'b0, "build_end");
    chk("build_const", 32'(o_Acc), 32'h1234);
    dbg_addr = 11'd3;
    sto(11'd3, "sto3");
    chk("sto3_dbg", 32'(o_DbgData), 32'h1234);
    ldi(11'h000, "clr");
    apply(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 11'd3, 1'b0, "ld3");
    chk("ld3_const", 32'(o_Acc), 32'h1234);

    // 0x200 doubled six times via RAM[20] gives 0x8000
    ldi(11'h200, "dbl0");
    for (int i = 0; i < 6; i++) begin
      sto(11'd20, "dbl_sto");
      apply(2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 11'd20, 1'b0,
            "dbl_add");
    end
    addi(11'h001, 1'b1, "subi");
    chk("subi_const", 32'(o_Acc), 32'h7FFF);
    addi(11'h001, 1'b0, "addi_wrap");
    chk("addi_wrap_const", 32'(o_Acc), 32'h8000);
    ldi(11'h000, "clr2");
    apply(2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 11'd3, 1'b0, "sub3");
    chk("sub3_const", 32'(o_Acc), 32'hEDCC);

    // Simultaneous WrRam + WrAcc + RdRam at address 7
    ldi(11'h055, "sim_pre");
    dbg_addr = 11'd7;
    sto(11'd7, "sim_sto");
    ldi(11'h0AA, "sim_ldi");
    apply(2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 11'd7, 1'b0, "sim");
    chk("sim_acc_const", 32'(o_Acc), 32'h0055);
    chk("sim_ram_const", 32'(o_DbgData), 32'h00AA);

    // Halt after 10 active cycles
    dbg_addr = 11'd3;
    do_reset(1'b0, 11'h0, "rst_h");
    for (int i = 0; i < 10; i++) nop("cnt");
    chk("cnt10", o_CycleCount, 32'd10);
    apply(2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 11'd3, 1'b1, "hlt");
    chk("hlt_flag", 32'(o_Halted), 32'd1);
    chk("hlt_cnt", o_CycleCount, 32'd10);
    chk("hlt_acc", 32'(o_Acc), 32'h0);
    sto(11'd3, "post_hlt_sto");
    chk("post_hlt_ram", 32'(o_DbgData), 32'h1234);
    chk("post_hlt_cnt", o_CycleCount, 32'd10);

    // Reset with a pending RAM write
    do_reset(1'b0, 11'h0, "rst_a");
    ldi(11'h3EE, "pre_rst");
    dbg_addr = 11'd9;
    do_reset(1'b1, 11'd9, "rst_wr");
    chk("rst_wr_ram", 32'(o_DbgData), 32'h0);
    chk("rst_wr_acc", 32'(o_Acc), 32'h0);

    // Random instruction stream on a small address window
    for (int n = 0; n < 600; n++) begin
      logic [10:0] opnd;
      opnd = ($urandom_range(0, 3) == 0) ? 11'($urandom)
                                         : 11'($urandom_range(0, 15));
      dbg_addr = ($urandom_range(0, 1) == 0) ? opnd
                                             : 11'($urandom_range(0, 15));
      if (halted_m && $urandom_range(0, 7) == 0) begin
        do_reset($urandom_range(0, 1) == 1, opnd, "rnd_rst");
      end else begin
        apply(2'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom), opnd,
              $urandom_range(0, 79) == 0, "rnd");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
